tl_ul_periph_demux: RTL and testbench

- TileLink-UL 1-to-2 address demultiplexer that sits directly upstream of the CLINT.
- Routes one master port to slave 0 (CLINT, 64 KiB window) or slave 1 (a second peripheral, e.g. PLIC), and steers the D-channel responses back.
- Addresses outside both windows go to an internal error responder, which returns a denied response.
- Keeps ordering safe by allowing outstanding requests to only one target at a time.

---
 rtl/tl_ul_pkg.sv | 29 ++
 rtl/tl_ul_err_responder.sv | 68 ++++++
 rtl/tl_ul_periph_demux.sv | 197 +++++++++++++++++++
 tb/tb_tl_ul_periph_demux.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcode encodings and the demux target selector.
// Also holds the opcode-to-response mapping used by the error responder.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;

  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_ERR = 2'd2
  } tgt_e;

  // Writes get a plain ack; anything that returns data gets AccessAckData.
  function automatic logic [2:0] resp_opcode(input logic [2:0] a_opcode);
    case (a_opcode)
      PUT_FULL, PUT_PARTIAL: return ACK;
      ARITH, LOGIC, GET:     return ACK_DATA;
      default:               return ACK_DATA;
    endcase
  endfunction

endpackage

// File: rtl/tl_ul_err_responder.sv
// One-entry error slot: remembers a request that decoded to no slave and
// answers it one cycle later with a denied response.
module tl_ul_err_responder
  import tl_ul_pkg::*;
#(
  parameter int TL_RS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             accept_i,
  input  logic             release_i,
  input  logic [2:0]       a_opcode_i,
  input  logic [3:0]       a_size_i,
  input  logic [TL_RS-1:0] a_source_i,
  output logic             err_valid_o,
  output logic [2:0]       d_opcode_o,
  output logic [1:0]       d_param_o,
  output logic [3:0]       d_size_o,
  output logic [TL_RS-1:0] d_source_o,
  output logic             d_denied_o,
  output logic [31:0]      d_data_o,
  output logic             d_corrupt_o
);

  logic             err_valid_q, err_valid_d;
  logic [2:0]       err_opcode_q, err_opcode_d;
  logic [3:0]       err_size_q, err_size_d;
  logic [TL_RS-1:0] err_source_q, err_source_d;

  always_comb begin
    err_valid_d  = err_valid_q;
    err_opcode_d = err_opcode_q;
    err_size_d   = err_size_q;
    err_source_d = err_source_q;
    if (accept_i) begin
      err_valid_d  = 1'b1;
      err_opcode_d = a_opcode_i;
      err_size_d   = a_size_i;
      err_source_d = a_source_i;
    end else if (release_i) begin
      err_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q  <= 1'b0;
      err_opcode_q <= '0;
      err_size_q   <= '0;
      err_source_q <= '0;
    end else begin
      err_valid_q  <= err_valid_d;
      err_opcode_q <= err_opcode_d;
      err_size_q   <= err_size_d;
      err_source_q <= err_source_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign d_opcode_o  = resp_opcode(err_opcode_q);
  assign d_param_o   = 2'd0;
  assign d_size_o    = err_size_q;
  assign d_source_o  = err_source_q;
  assign d_denied_o  = 1'b1;
  assign d_data_o    = 32'd0;
  assign d_corrupt_o = (resp_opcode(err_opcode_q) == ACK_DATA);

endmodule

// File: rtl/tl_ul_periph_demux.sv
// TileLink-UL 1-to-2 demux in front of the CLINT (slave 0) and a second
// peripheral (slave 1); unmapped addresses go to a local error responder.
module tl_ul_periph_demux
  import tl_ul_pkg::*;
#(
  parameter int             TL_RS   = 4,
  parameter int             AW      = 32,
  parameter logic [AW-1:0]  S0_BASE = 32'h0200_0000,
  parameter logic [AW-1:0]  S1_BASE = 32'h0C00_0000,
  parameter logic [AW-1:0]  S1_MASK = 32'h03FF_FFFF,
  parameter int             MAX_OUT = 4
) (
  input  logic             demux_clock_i,
  input  logic             demux_reset_i,
  input  logic [2:0]       m_a_opcode,
  input  logic [2:0]       m_a_param,
  input  logic [3:0]       m_a_size,
  input  logic [TL_RS-1:0] m_a_source,
  input  logic [AW-1:0]    m_a_address,
  input  logic [3:0]       m_a_mask,
  input  logic [31:0]      m_a_data,
  input  logic             m_a_valid,
  output logic             m_a_ready,
  output logic [2:0]       m_d_opcode,
  output logic [1:0]       m_d_param,
  output logic [3:0]       m_d_size,
  output logic [TL_RS-1:0] m_d_source,
  output logic             m_d_denied,
  output logic [31:0]      m_d_data,
  output logic             m_d_corrupt,
  output logic             m_d_valid,
  input  logic             m_d_ready,
  output logic [2:0]       s0_a_opcode,
  output logic [2:0]       s0_a_param,
  output logic [3:0]       s0_a_size,
  output logic [TL_RS-1:0] s0_a_source,
  output logic [15:0]      s0_a_address,
  output logic [3:0]       s0_a_mask,
  output logic [31:0]      s0_a_data,
  output logic             s0_a_valid,
  input  logic             s0_a_ready,
  input  logic [2:0]       s0_d_opcode,
  input  logic [1:0]       s0_d_param,
  input  logic [3:0]       s0_d_size,
  input  logic [TL_RS-1:0] s0_d_source,
  input  logic             s0_d_denied,
  input  logic [31:0]      s0_d_data,
  input  logic             s0_d_corrupt,
  input  logic             s0_d_valid,
  output logic             s0_d_ready,
  output logic [2:0]       s1_a_opcode,
  output logic [2:0]       s1_a_param,
  output logic [3:0]       s1_a_size,
  output logic [TL_RS-1:0] s1_a_source,
  output logic [AW-1:0]    s1_a_address,
  output logic [3:0]       s1_a_mask,
  output logic [31:0]      s1_a_data,
  output logic             s1_a_valid,
  input  logic             s1_a_ready,
  input  logic [2:0]       s1_d_opcode,
  input  logic [1:0]       s1_d_param,
  input  logic [3:0]       s1_d_size,
  input  logic [TL_RS-1:0] s1_d_source,
  input  logic             s1_d_denied,
  input  logic [31:0]      s1_d_data,
  input  logic             s1_d_corrupt,
  input  logic             s1_d_valid,
  output logic             s1_d_ready
);

  localparam int            CW      = $clog2(MAX_OUT + 1);
  localparam logic [AW-1:0] S0_MASK = AW'(32'h0000_FFFF);

  tgt_e             tgt, cur_tgt_q, cur_tgt_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             busy, stall, a_fire, d_fire, sel_valid;
  logic             err_valid, err_denied, err_corrupt;
  logic [2:0]       err_opcode;
  logic [1:0]       err_param;
  logic [3:0]       err_size;
  logic [TL_RS-1:0] err_source;
  logic [31:0]      err_data;

  always_comb begin
    if ((m_a_address & ~S0_MASK) == S0_BASE)      tgt = TGT_S0;
    else if ((m_a_address & ~S1_MASK) == S1_BASE) tgt = TGT_S1;
    else                                          tgt = TGT_ERR;
  end

  // Only one target may have requests in flight, so responses never reorder.
  assign busy  = (out_cnt_q != '0);
  assign stall = (out_cnt_q == CW'(MAX_OUT)) | (busy & (tgt != cur_tgt_q));

  always_comb begin
    case (tgt)
      TGT_S0:  m_a_ready = ~stall & s0_a_ready;
      TGT_S1:  m_a_ready = ~stall & s1_a_ready;
      default: m_a_ready = ~stall & ~err_valid;
    endcase
  end

  assign a_fire = m_a_valid & m_a_ready;
  assign d_fire = m_d_valid & m_d_ready;

  assign s0_a_valid   = m_a_valid & (tgt == TGT_S0) & ~stall;
  assign s0_a_opcode  = m_a_opcode;
  assign s0_a_param   = m_a_param;
  assign s0_a_size    = m_a_size;
  assign s0_a_source  = m_a_source;
  assign s0_a_address = m_a_address[15:0];
  assign s0_a_mask    = m_a_mask;
  assign s0_a_data    = m_a_data;

  assign s1_a_valid   = m_a_valid & (tgt == TGT_S1) & ~stall;
  assign s1_a_opcode  = m_a_opcode;
  assign s1_a_param   = m_a_param;
  assign s1_a_size    = m_a_size;
  assign s1_a_source  = m_a_source;
  assign s1_a_address = m_a_address & S1_MASK;
  assign s1_a_mask    = m_a_mask;
  assign s1_a_data    = m_a_data;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (a_fire & ~d_fire)      out_cnt_d = out_cnt_q + CW'(1);
    else if (d_fire & ~a_fire) out_cnt_d = out_cnt_q - CW'(1);
    cur_tgt_d = a_fire ? tgt : cur_tgt_q;
  end

  always_ff @(posedge demux_clock_i or posedge demux_reset_i) begin
    if (demux_reset_i) begin
      out_cnt_q <= '0;
      cur_tgt_q <= TGT_S0;
    end else begin
      out_cnt_q <= out_cnt_d;
      cur_tgt_q <= cur_tgt_d;
    end
  end

  tl_ul_err_responder #(.TL_RS(TL_RS)) u_err (
    .clk_i       (demux_clock_i),
    .rst_i       (demux_reset_i),
    .accept_i    (a_fire & (tgt == TGT_ERR)),
    .release_i   (d_fire & (cur_tgt_q == TGT_ERR)),
    .a_opcode_i  (m_a_opcode),
    .a_size_i    (m_a_size),
    .a_source_i  (m_a_source),
    .err_valid_o (err_valid),
    .d_opcode_o  (err_opcode),
    .d_param_o   (err_param),
    .d_size_o    (err_size),
    .d_source_o  (err_source),
    .d_denied_o  (err_denied),
    .d_data_o    (err_data),
    .d_corrupt_o (err_corrupt)
  );

  always_comb begin
    sel_valid   = err_valid;
    m_d_opcode  = err_opcode;
    m_d_param   = err_param;
    m_d_size    = err_size;
    m_d_source  = err_source;
    m_d_denied  = err_denied;
    m_d_data    = err_data;
    m_d_corrupt = err_corrupt;
    case (cur_tgt_q)
      TGT_S0: begin
        sel_valid   = s0_d_valid;
        m_d_opcode  = s0_d_opcode;
        m_d_param   = s0_d_param;
        m_d_size    = s0_d_size;
        m_d_source  = s0_d_source;
        m_d_denied  = s0_d_denied;
        m_d_data    = s0_d_data;
        m_d_corrupt = s0_d_corrupt;
      end
      TGT_S1: begin
        sel_valid   = s1_d_valid;
        m_d_opcode  = s1_d_opcode;
        m_d_param   = s1_d_param;
        m_d_size    = s1_d_size;
        m_d_source  = s1_d_source;
        m_d_denied  = s1_d_denied;
        m_d_data    = s1_d_data;
        m_d_corrupt = s1_d_corrupt;
      end
      default: ;
    endcase
  end

  // Gating on busy hides stray slave responses when nothing is in flight.
  assign m_d_valid  = sel_valid & busy;
  assign s0_d_ready = m_d_ready & (cur_tgt_q == TGT_S0) & busy;
  assign s1_d_ready = m_d_ready & (cur_tgt_q == TGT_S1) & busy;

endmodule

// File: tb/tb_tl_ul_periph_demux.sv
// Directed bench for tl_ul_periph_demux: a decode/forwarding vector table
// followed by hand-written multi-cycle sequences.
module tb_tl_ul_periph_demux;
  import tl_ul_pkg::*;

  logic        demux_clock_i = 1'b0;
  logic        demux_reset_i;
  logic [2:0]  m_a_opcode, m_a_param;
  logic [3:0]  m_a_size, m_a_source, m_a_mask;
  logic [31:0] m_a_address, m_a_data;
  logic        m_a_valid, m_a_ready;
  logic [2:0]  m_d_opcode;
  logic [1:0]  m_d_param;
  logic [3:0]  m_d_size, m_d_source;
  logic        m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
  logic [31:0] m_d_data;
  logic [2:0]  s0_a_opcode, s0_a_param, s1_a_opcode, s1_a_param;
  logic [3:0]  s0_a_size, s0_a_source, s0_a_mask, s1_a_size, s1_a_source, s1_a_mask;
  logic [15:0] s0_a_address;
  logic [31:0] s1_a_address, s0_a_data, s1_a_data;
  logic        s0_a_valid, s0_a_ready, s1_a_valid, s1_a_ready;
  logic [2:0]  s0_d_opcode, s1_d_opcode;
  logic [1:0]  s0_d_param, s1_d_param;
  logic [3:0]  s0_d_size, s0_d_source, s1_d_size, s1_d_source;
  logic        s0_d_denied, s0_d_corrupt, s0_d_valid, s0_d_ready;
  logic        s1_d_denied, s1_d_corrupt, s1_d_valid, s1_d_ready;
  logic [31:0] s0_d_data, s1_d_data;

  int checks = 0;
  int passes = 0;

  always #5 demux_clock_i = ~demux_clock_i;

  tl_ul_periph_demux dut (
    .demux_clock_i(demux_clock_i), .demux_reset_i(demux_reset_i),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_denied(m_d_denied), .m_d_data(m_d_data),
    .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .s0_a_opcode(s0_a_opcode), .s0_a_param(s0_a_param), .s0_a_size(s0_a_size),
    .s0_a_source(s0_a_source), .s0_a_address(s0_a_address), .s0_a_mask(s0_a_mask),
    .s0_a_data(s0_a_data), .s0_a_valid(s0_a_valid), .s0_a_ready(s0_a_ready),
    .s0_d_opcode(s0_d_opcode), .s0_d_param(s0_d_param), .s0_d_size(s0_d_size),
    .s0_d_source(s0_d_source), .s0_d_denied(s0_d_denied), .s0_d_data(s0_d_data),
    .s0_d_corrupt(s0_d_corrupt), .s0_d_valid(s0_d_valid), .s0_d_ready(s0_d_ready),
    .s1_a_opcode(s1_a_opcode), .s1_a_param(s1_a_param), .s1_a_size(s1_a_size),
    .s1_a_source(s1_a_source), .s1_a_address(s1_a_address), .s1_a_mask(s1_a_mask),
    .s1_a_data(s1_a_data), .s1_a_valid(s1_a_valid), .s1_a_ready(s1_a_ready),
    .s1_d_opcode(s1_d_opcode), .s1_d_param(s1_d_param), .s1_d_size(s1_d_size),
    .s1_d_source(s1_d_source), .s1_d_denied(s1_d_denied), .s1_d_data(s1_d_data),
    .s1_d_corrupt(s1_d_corrupt), .s1_d_valid(s1_d_valid), .s1_d_ready(s1_d_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  opcode;
    logic        valid, s0Rdy, s1Rdy;
    logic        expS0Valid, expS1Valid, expReady;
    logic [15:0] expS0Addr;
    logic [31:0] expS1Addr;
  } vecT;

  vecT vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] opcode,
                               input logic [31:0] addr, input logic [3:0] source);
    m_a_valid   = valid;
    m_a_opcode  = opcode;
    m_a_address = addr;
    m_a_source  = source;
    m_a_size    = 4'd2;
  endtask

  task automatic driveS0D(input logic valid, input logic [2:0] opcode,
                          input logic [3:0] source, input logic [31:0] data);
    s0_d_valid = valid; s0_d_opcode = opcode; s0_d_source = source; s0_d_data = data;
  endtask

  task automatic driveS1D(input logic valid, input logic [2:0] opcode,
                          input logic [3:0] source, input logic [31:0] data);
    s1_d_valid = valid; s1_d_opcode = opcode; s1_d_source = source; s1_d_data = data;
  endtask

  task automatic step();
    @(posedge demux_clock_i);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0200_BFF8, GET,      1, 1, 1, 1, 0, 1, 16'hBFF8, 32'h0200_BFF8};
    vecs[1] = '{32'h0200_BFF8, GET,      1, 0, 1, 1, 0, 0, 16'hBFF8, 32'h0200_BFF8};
    vecs[2] = '{32'h0C00_0004, PUT_FULL, 1, 1, 1, 0, 1, 1, 16'h0004, 32'h0000_0004};
    vecs[3] = '{32'h0C00_0004, PUT_FULL, 1, 1, 0, 0, 1, 0, 16'h0004, 32'h0000_0004};
    vecs[4] = '{32'h1000_0000, GET,      1, 0, 0, 0, 0, 1, 16'h0000, 32'h0000_0000};
    vecs[5] = '{32'h0201_0000, GET,      1, 1, 1, 0, 0, 1, 16'h0000, 32'h0201_0000};
    vecs[6] = '{32'h0FFF_FFFC, GET,      1, 0, 1, 0, 1, 1, 16'hFFFC, 32'h03FF_FFFC};
    vecs[7] = '{32'h01FF_FFFF, GET,      1, 1, 1, 0, 0, 1, 16'hFFFF, 32'h01FF_FFFF};
    vecs[8] = '{32'h0200_0000, GET,      0, 1, 0, 0, 0, 1, 16'h0000, 32'h0200_0000};
    vecs[9] = '{32'h0200_FFFF, ARITH,    1, 1, 0, 1, 0, 1, 16'hFFFF, 32'h0200_FFFF};

    demux_reset_i = 1'b1;
    applyStimulus(0, GET, 32'h0, 4'd0);
    m_a_param = 3'd0; m_a_mask = 4'hF; m_a_data = 32'h0; m_d_ready = 1'b0;
    s0_a_ready = 1'b1; s1_a_ready = 1'b1;
    driveS0D(1, ACK_DATA, 4'd0, 32'hAAAA);
    driveS1D(1, ACK_DATA, 4'd0, 32'hBBBB);
    s0_d_param = 2'd0; s0_d_size = 4'd2; s0_d_denied = 1'b0; s0_d_corrupt = 1'b0;
    s1_d_param = 2'd0; s1_d_size = 4'd2; s1_d_denied = 1'b0; s1_d_corrupt = 1'b0;
    #2;
    checkOutput("rst_m_d_valid", m_d_valid, 0);
    checkOutput("rst_s0_a_valid", s0_a_valid, 0);
    checkOutput("rst_s1_a_valid", s1_a_valid, 0);
    checkOutput("rst_m_a_ready", m_a_ready, 1);
    step(); step();
    demux_reset_i = 1'b0;
    driveS0D(0, ACK_DATA, 4'd0, 32'h0);
    driveS1D(0, ACK_DATA, 4'd0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      step();
      applyStimulus(vecs[i].valid, vecs[i].opcode, vecs[i].addr, 4'd1);
      s0_a_ready = vecs[i].s0Rdy;
      s1_a_ready = vecs[i].s1Rdy;
      #1;
      checkOutput($sformatf("vec%0d_s0_a_valid", i), s0_a_valid, vecs[i].expS0Valid);
      checkOutput($sformatf("vec%0d_s1_a_valid", i), s1_a_valid, vecs[i].expS1Valid);
      checkOutput($sformatf("vec%0d_m_a_ready", i), m_a_ready, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_s0_a_address", i), s0_a_address, vecs[i].expS0Addr);
      checkOutput($sformatf("vec%0d_s1_a_address", i), s1_a_address, vecs[i].expS1Addr);
      m_a_valid = 1'b0;
    end

    // Get to the CLINT and its data response.
    step();
    applyStimulus(1, GET, 32'h0200_BFF8, 4'd5);
    s0_a_ready = 1'b1; s1_a_ready = 1'b1;
    #1;
    checkOutput("s0get_s0_a_valid", s0_a_valid, 1);
    checkOutput("s0get_s0_a_address", s0_a_address, 32'hBFF8);
    checkOutput("s0get_s0_a_source", s0_a_source, 5);
    step();
    m_a_valid = 1'b0;
    driveS0D(1, ACK_DATA, 4'd5, 32'h1234);
    m_d_ready = 1'b1;
    #1;
    checkOutput("s0get_m_d_valid", m_d_valid, 1);
    checkOutput("s0get_m_d_data", m_d_data, 32'h1234);
    checkOutput("s0get_m_d_opcode", m_d_opcode, 1);
    checkOutput("s0get_m_d_source", m_d_source, 5);
    checkOutput("s0get_s0_d_ready", s0_d_ready, 1);
    step();
    checkOutput("s0get_drained_m_d_valid", m_d_valid, 0);
    checkOutput("s0get_drained_s0_d_ready", s0_d_ready, 0);
    s0_d_valid = 1'b0;

    // PutFull to slave 1; a stray slave-0 response must not be routed.
    step();
    applyStimulus(1, PUT_FULL, 32'h0C00_0004, 4'd3);
    #1;
    checkOutput("s1put_s1_a_valid", s1_a_valid, 1);
    checkOutput("s1put_s1_a_address", s1_a_address, 32'h4);
    checkOutput("s1put_s0_a_valid", s0_a_valid, 0);
    step();
    m_a_valid = 1'b0;
    driveS1D(1, ACK, 4'd3, 32'h0);
    driveS0D(1, ACK_DATA, 4'd7, 32'hDEAD);
    #1;
    checkOutput("s1put_m_d_valid", m_d_valid, 1);
    checkOutput("s1put_m_d_opcode", m_d_opcode, 0);
    checkOutput("s1put_m_d_source", m_d_source, 3);
    checkOutput("s1put_m_d_data", m_d_data, 0);
    checkOutput("s1put_s1_d_ready", s1_d_ready, 1);
    checkOutput("s1put_s0_d_ready", s0_d_ready, 0);
    step();
    s1_d_valid = 1'b0; s0_d_valid = 1'b0;
    #1;
    checkOutput("s1put_drained_m_d_valid", m_d_valid, 0);

    // Unmapped Get, then a second error request blocked by the full slot.
    step();
    applyStimulus(1, GET, 32'h1000_0000, 4'd9);
    m_d_ready = 1'b0;
    #1;
    checkOutput("err_m_a_ready", m_a_ready, 1);
    checkOutput("err_no_s_valid", {s0_a_valid, s1_a_valid}, 0);
    step();
    applyStimulus(1, PUT_FULL, 32'h1000_0010, 4'd10);
    #1;
    checkOutput("err_m_d_valid", m_d_valid, 1);
    checkOutput("err_m_d_denied", m_d_denied, 1);
    checkOutput("err_m_d_corrupt", m_d_corrupt, 1);
    checkOutput("err_m_d_opcode", m_d_opcode, 1);
    checkOutput("err_m_d_data", m_d_data, 0);
    checkOutput("err_m_d_param", m_d_param, 0);
    checkOutput("err_m_d_source", m_d_source, 9);
    checkOutput("err_m_d_size", m_d_size, 2);
    checkOutput("err2_stalled", m_a_ready, 0);
    step();
    checkOutput("err2_still_stalled", m_a_ready, 0);
    checkOutput("err_held_m_d_valid", m_d_valid, 1);
    m_d_ready = 1'b1;
    #1;
    checkOutput("err2_stalled_during_dfire", m_a_ready, 0);
    step();
    checkOutput("err2_ready_after_drain", m_a_ready, 1);
    checkOutput("err_drained_m_d_valid", m_d_valid, 0);
    step();
    m_a_valid = 1'b0;
    #1;
    checkOutput("err2_m_d_valid", m_d_valid, 1);
    checkOutput("err2_m_d_opcode", m_d_opcode, 0);
    checkOutput("err2_m_d_corrupt", m_d_corrupt, 0);
    checkOutput("err2_m_d_denied", m_d_denied, 1);
    checkOutput("err2_m_d_source", m_d_source, 10);
    step();
    checkOutput("err2_drained_m_d_valid", m_d_valid, 0);

    // Two slave-0 Gets in flight block a slave-1 Get until both drain.
    step();
    applyStimulus(1, GET, 32'h0200_0010, 4'd1);
    step();
    applyStimulus(1, GET, 32'h0200_0010, 4'd2);
    #1;
    checkOutput("order_second_s0_ready", m_a_ready, 1);
    step();
    applyStimulus(1, GET, 32'h0C00_0020, 4'd4);
    #1;
    checkOutput("order_s1_blocked_ready", m_a_ready, 0);
    checkOutput("order_s1_blocked_valid", s1_a_valid, 0);
    driveS0D(1, ACK_DATA, 4'd1, 32'h11);
    #1;
    checkOutput("order_s1_blocked_cnt2", m_a_ready, 0);
    step();
    checkOutput("order_s1_blocked_cnt1", m_a_ready, 0);
    checkOutput("order_second_resp_valid", m_d_valid, 1);
    step();
    checkOutput("order_s1_ready", m_a_ready, 1);
    checkOutput("order_s1_valid", s1_a_valid, 1);
    checkOutput("order_s0_drained_m_d_valid", m_d_valid, 0);
    s0_d_valid = 1'b0;
    step();
    m_a_valid = 1'b0;
    driveS1D(1, ACK_DATA, 4'd4, 32'h55);
    #1;
    checkOutput("order_s1_m_d_valid", m_d_valid, 1);
    checkOutput("order_s1_m_d_data", m_d_data, 32'h55);
    step();
    s1_d_valid = 1'b0;

    // Fill to MAX_OUT, then a simultaneous accept and response.
    step();
    applyStimulus(1, GET, 32'h0200_0100, 4'd6);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("maxout_accept%0d", k), m_a_ready, 1);
      step();
    end
    #1;
    checkOutput("maxout_fifth_ready", m_a_ready, 0);
    checkOutput("maxout_fifth_valid", s0_a_valid, 0);
    driveS0D(1, ACK_DATA, 4'd6, 32'h66);
    #1;
    checkOutput("maxout_full_during_dfire", m_a_ready, 0);
    step();
    checkOutput("maxout_ready_at3", m_a_ready, 1);
    step();
    s0_d_valid = 1'b0;
    #1;
    checkOutput("maxout_simul_keeps3", m_a_ready, 1);
    step();
    checkOutput("maxout_full_again", m_a_ready, 0);
    m_a_valid = 1'b0;

    // Drain to two outstanding, then reset asynchronously mid-cycle.
    s0_d_valid = 1'b1;
    step();
    step();
    m_d_ready = 1'b0;
    #1;
    checkOutput("rst2_m_d_valid_before", m_d_valid, 1);
    applyStimulus(1, PUT_FULL, 32'h0C00_0000, 4'd7);
    m_d_ready = 1'b1;
    #1;
    checkOutput("rst2_s1_blocked", m_a_ready, 0);
    demux_reset_i = 1'b1;
    #1;
    checkOutput("rst2_m_d_valid", m_d_valid, 0);
    checkOutput("rst2_s0_d_ready", s0_d_ready, 0);
    checkOutput("rst2_s1_a_valid", s1_a_valid, 1);
    checkOutput("rst2_m_a_ready", m_a_ready, 1);
    step();
    m_a_valid = 1'b0;
    demux_reset_i = 1'b0;
    #1;
    checkOutput("rst2_after_m_d_valid", m_d_valid, 0);
    s0_d_valid = 1'b0;

    // Reset with an error response pending clears the slot.
    step();
    applyStimulus(1, GET, 32'h1000_0000, 4'd8);
    m_d_ready = 1'b0;
    step();
    m_a_valid = 1'b0;
    #1;
    checkOutput("rst_err_pending", m_d_valid, 1);
    demux_reset_i = 1'b1;
    #1;
    checkOutput("rst_err_m_d_valid", m_d_valid, 0);
    step();
    demux_reset_i = 1'b0;
    applyStimulus(1, GET, 32'h1000_0000, 4'd11);
    #1;
    checkOutput("rst_err_slot_free", m_a_ready, 1);
    m_a_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
